// File: rtl/smpc_pad_port.sv
// Saturn control-port scanner: 4 TH/TR select phases -> atomic 16-bit JOY word; START-to-DONE = 4*(SETTLE_CYC+2)+1 CE cycles.
// No backpressure: START is ignored while a scan runs; optional periodic auto-scan with SMPC_PAD_AUTOSCAN_EN.
module smpc_pad_port #(
  parameter int SETTLE_CYC  = 16
`ifdef SMPC_PAD_AUTOSCAN_EN
  ,
  parameter int AUTO_PERIOD = 65536
`endif
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CE,
  input  logic        START,
  input  logic [6:0]  PI,
  output logic [6:0]  PO,
  output logic [6:0]  PDIR,
  output logic        BUSY,
  output logic        DONE,
  output logic        PRESENT,
  output logic [15:0] JOY
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  localparam logic [2:0] PAD_ID = 3'b100;

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  phase;
  logic [7:0]  cnt;
  logic [3:0]  shadow [0:3];
  logic [15:0] joy_q;
  logic        present_q;
  logic        go;
  logic [1:0]  sel;
  logic [2:0]  unused_pi;

  assign unused_pi = PI[6:4];

`ifdef SMPC_PAD_AUTOSCAN_EN
  localparam int AW = $clog2(AUTO_PERIOD);
  localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_PERIOD - 1);

  logic [AW-1:0] auto_cnt;
  logic          auto_go;

  always_ff @(posedge CLK) begin
    if (RST) begin
      auto_cnt <= '0;
    end else if (CE) begin
      auto_cnt <= (auto_cnt == AUTO_LAST) ? '0 : auto_cnt + 1'b1;
    end
  end

  // An auto-start landing mid-scan is simply lost: only IDLE looks at go.
  assign auto_go = (auto_cnt == AUTO_LAST);
  assign go      = START | auto_go;
`else
  assign go = START;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (go) state_nxt = S_DRIVE;
      S_DRIVE:  state_nxt = S_SETTLE;
      S_SETTLE: if (cnt == 8'd0) state_nxt = S_SAMPLE;
      S_SAMPLE: state_nxt = (phase == 2'd3) ? S_DONE : S_DRIVE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_IDLE;
      phase     <= 2'd0;
      cnt       <= 8'd0;
      shadow    <= '{default: 4'hF};
      joy_q     <= 16'hFFFF;
      present_q <= 1'b0;
    end else if (CE) begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (go) phase <= 2'd0;
        end
        S_DRIVE: begin
          cnt <= 8'(SETTLE_CYC - 1);
        end
        S_SETTLE: begin
          if (cnt != 8'd0) cnt <= cnt - 8'd1;
        end
        S_SAMPLE: begin
          shadow[phase] <= PI[3:0];
          phase         <= phase + 2'd1;
          // Last nibble comes straight from the pins so JOY is ready in the DONE cycle.
          if (phase == 2'd3) begin
            present_q <= (shadow[0][2:0] == PAD_ID);
            joy_q     <= (shadow[0][2:0] == PAD_ID)
                         ? {shadow[1], shadow[2], PI[3:0], shadow[0][3], PAD_ID}
                         : 16'hFFFF;
          end
        end
        default: ;
      endcase
    end
  end

  // Phase order {TH,TR}: 11, 01, 10, 00; idle/done park both high.
  always_comb begin
    sel = 2'b11;
    if (state == S_DRIVE || state == S_SETTLE || state == S_SAMPLE) begin
      sel = {~phase[0], ~phase[1]};
    end
  end

  assign PO      = {sel, 5'b0_0000};
  assign PDIR    = 7'h60;
  assign BUSY    = (state == S_DRIVE) || (state == S_SETTLE) || (state == S_SAMPLE);
  assign DONE    = (state == S_DONE);
  assign PRESENT = present_q;
  assign JOY     = joy_q;

endmodule

// File: tb/tb_smpc_pad_port.sv
// Bench for smpc_pad_port: behavioural pad model on the pins, randomized button/ID patterns, reference JOY from button list.
module tb_smpc_pad_port;

  localparam int SETTLE = 4;
  localparam int LAT    = 4 * (SETTLE + 2) + 1;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        CE = 1'b1;
  logic        START = 1'b0;
  logic [6:0]  PI;
  logic [6:0]  PO;
  logic [6:0]  PDIR;
  logic        BUSY;
  logic        DONE;
  logic        PRESENT;
  logic [15:0] JOY;

  int checks = 0;
  int failures = 0;

  // Pad model: pressed[b] = 1 means the button feeding JOY bit b is pressed.
  logic [15:3] pressed = '0;
  logic [2:0]  pad_id = 3'b100;
  bit          open_port = 1'b0;
  logic [3:0]  nib;

  smpc_pad_port #(.SETTLE_CYC(SETTLE)) dut (
    .CLK(CLK), .RST(RST), .CE(CE), .START(START), .PI(PI),
    .PO(PO), .PDIR(PDIR), .BUSY(BUSY), .DONE(DONE), .PRESENT(PRESENT), .JOY(JOY)
  );

  always #5 CLK = ~CLK;

  always_comb begin
    nib = 4'hF;
    case (PO[6:5])
      2'b11: nib = {~pressed[3], pad_id};
      2'b01: nib = ~pressed[15:12];
      2'b10: nib = ~pressed[11:8];
      2'b00: nib = ~pressed[7:4];
      default: nib = 4'hF;
    endcase
    PI = open_port ? 7'h7F : {PO[6:5], 1'b1, nib};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_joy();
    if (open_port || pad_id != 3'b100) return 16'hFFFF;
    return {~pressed, 3'b100};
  endfunction

  function automatic logic ref_present();
    return !open_port && pad_id == 3'b100;
  endfunction

  // One scan: START pulse, then watch until DONE (bounded); optional CE toggling and START re-pulse.
  task automatic scan(input string tag, input bit tog, input int restart_at);
    int          n = 0;
    int          hold_err = 0;
    int          extra = 0;
    logic [15:0] prev_joy = JOY;
    logic        prev_pres = PRESENT;
    logic [31:0] seq = 32'd1;
    logic [1:0]  last_sel = PO[6:5];
    logic [15:0] exp_joy = ref_joy();
    logic        exp_pres = ref_present();
    seq = {seq[29:0], last_sel};
    START = 1'b1;
    CE = 1'b1;
    do begin
      @(posedge CLK);
      n++;
      #1;
      START = (n == restart_at);
      if (tog) CE = ~CE;
      if (PO[6:5] != last_sel) begin
        last_sel = PO[6:5];
        seq = {seq[29:0], last_sel};
      end
      if (n == 5) check({tag, "_busy_mid"}, {31'd0, BUSY}, 32'd1);
      if (!DONE && (JOY !== prev_joy || PRESENT !== prev_pres)) hold_err++;
    end while (!DONE && n < 200);
    check({tag, "_latency"}, n, tog ? 2 * LAT - 1 : LAT);
    check({tag, "_joy"}, {16'd0, JOY}, {16'd0, exp_joy});
    check({tag, "_present"}, {31'd0, PRESENT}, {31'd0, exp_pres});
    check({tag, "_busy_done"}, {31'd0, BUSY}, 32'd0);
    check({tag, "_hold"}, hold_err, 0);
    check({tag, "_po_seq"}, seq, 32'b1_11_01_10_00_11);
    START = 1'b0;
    CE = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge CLK);
      #1;
      if (DONE) extra++;
    end
    check({tag, "_single_done"}, extra, 0);
  endtask

  initial begin
    int cnt_done;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    check("rst_po", {25'd0, PO}, 32'h60);
    check("rst_pdir", {25'd0, PDIR}, 32'h60);
    check("rst_joy", {16'd0, JOY}, 32'hFFFF);
    check("rst_present", {31'd0, PRESENT}, 32'd0);
    check("rst_busy", {31'd0, BUSY}, 32'd0);
    check("rst_done", {31'd0, DONE}, 32'd0);
    @(posedge CLK);
    #1;

    pressed = '0;
    scan("released", 1'b0, 0);
    check("released_value", {16'd0, JOY}, 32'hFFFC);

    pressed = '0;
    pressed[12] = 1'b1;
    pressed[10] = 1'b1;
    pressed[4] = 1'b1;
    pressed[3] = 1'b1;
    scan("up_a_z_l", 1'b0, 0);
    check("up_a_z_l_value", {16'd0, JOY}, 32'hEBE4);

    open_port = 1'b1;
    scan("open", 1'b0, 0);
    open_port = 1'b0;

    pressed = 13'h0A5A;
    scan("restart", 1'b0, 10);

    pressed = 13'h1234;
    scan("ce_toggle", 1'b1, 0);

    // Reset in the middle of a scan must abort it silently.
    START = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
    repeat (11) @(posedge CLK);
    #1;
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check("midrst_po", {25'd0, PO}, 32'h60);
    check("midrst_joy", {16'd0, JOY}, 32'hFFFF);
    check("midrst_present", {31'd0, PRESENT}, 32'd0);
    check("midrst_busy", {31'd0, BUSY}, 32'd0);
    RST = 1'b0;
    cnt_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge CLK);
      #1;
      if (DONE) cnt_done++;
    end
    check("midrst_no_done", cnt_done, 0);
    pressed = 13'h0F0F;
    scan("after_rst", 1'b0, 0);

    for (int k = 0; k < 8; k++) begin
      pressed = 13'($urandom);
      pad_id = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b100;
      scan($sformatf("rand%0d", k), 1'($urandom_range(0, 1)), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
